vsi_codecheck: RTL

Sink-side checker for the VSI incrementing code stream. Samples a DATA_WIDTH-bit data word on every `valid` cycle and compares it against an internally tracked expected count (0, 1, 2, … all-ones). Reports a saturating mismatch count, a completion flag and a pass verdict. Sits at the far end of the VSI code link, opposite the code generator, and is the loopback/self-test verdict source.

---
 rtl/vsi_pkg.sv | 14 +
 rtl/vsi_sat_cnt.sv | 33 +++
 rtl/vsi_codecheck.sv | 116 +++++++++++
 3 files changed

// File: rtl/vsi_pkg.sv
// Shared VSI code-link definitions: checker state encoding and default widths
// common to the code generator and the code checker.
package vsi_pkg;

  localparam int VSI_DATA_WIDTH = 8;
  localparam int VSI_ERR_WIDTH  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_DONE  = 2'd2
  } vsi_state_e;

endpackage

// File: rtl/vsi_sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones once reached.
module vsi_sat_cnt #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/vsi_codecheck.sv
// Sink-side checker for the VSI incrementing code stream (0..all-ones).
// Define VSI_CODECHECK_ERRLOG_EN to capture expected/received at first mismatch.
module vsi_codecheck
  import vsi_pkg::*;
#(
  parameter int DATA_WIDTH    = VSI_DATA_WIDTH,
  parameter int ERR_WIDTH     = VSI_ERR_WIDTH,
  parameter int SYNC_ON_FIRST = 0
) (
  input  logic                  clk,
  input  logic                  rst_l,
  input  logic                  clear,
  input  logic                  valid,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ERR_WIDTH-1:0]  err_cnt,
  output logic                  err_pulse,
  output logic [DATA_WIDTH-1:0] first_err_exp,
  output logic [DATA_WIDTH-1:0] first_err_got
);

  vsi_state_e            state_q;
  logic [DATA_WIDTH-1:0] exp_q, exp_d;
  logic                  busy_q, done_q, pass_q, errPulse_q;
  logic [ERR_WIDTH-1:0]  errCnt;

  logic                  sample, isSeed, mismatch, isLast;
  logic [DATA_WIDTH-1:0] cmpExp;

  // In IDLE with sync enabled the first word becomes its own reference.
  assign sample   = valid && !clear && (state_q != ST_DONE);
  assign isSeed   = (SYNC_ON_FIRST != 0) && (state_q == ST_IDLE);
  assign cmpExp   = isSeed ? data : exp_q;
  assign mismatch = sample && (data != cmpExp);
  assign isLast   = (cmpExp == '1);
  assign exp_d    = cmpExp + 1'b1;

  vsi_sat_cnt #(
    .WIDTH(ERR_WIDTH)
  ) u_errCnt (
    .clk  (clk),
    .rst_l(rst_l),
    .clr_i(clear),
    .inc_i(mismatch),
    .cnt_o(errCnt)
  );

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q    <= ST_IDLE;
      exp_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      errPulse_q <= 1'b0;
    end else if (clear) begin
      state_q    <= ST_IDLE;
      exp_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      errPulse_q <= 1'b0;
    end else begin
      errPulse_q <= mismatch;
      if (sample) begin
        // The all-ones position terminates the run; expected never wraps.
        if (isLast) begin
          state_q <= ST_DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          pass_q  <= (errCnt == '0) && !mismatch;
        end else begin
          state_q <= ST_CHECK;
          busy_q  <= 1'b1;
          exp_q   <= exp_d;
        end
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_cnt   = errCnt;
  assign err_pulse = errPulse_q;

`ifdef VSI_CODECHECK_ERRLOG_EN
  logic                  logged_q;
  logic [DATA_WIDTH-1:0] firstExp_q, firstGot_q;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      logged_q   <= 1'b0;
      firstExp_q <= '0;
      firstGot_q <= '0;
    end else if (clear) begin
      logged_q   <= 1'b0;
      firstExp_q <= '0;
      firstGot_q <= '0;
    end else if (mismatch && !logged_q) begin
      logged_q   <= 1'b1;
      firstExp_q <= cmpExp;
      firstGot_q <= data;
    end
  end

  assign first_err_exp = firstExp_q;
  assign first_err_got = firstGot_q;
`else
  assign first_err_exp = '0;
  assign first_err_got = '0;
`endif

endmodule
